// File: rtl/spi_reg_master.sv
// SPI initiator for 16-bit {addr, val} register-bank and pass-through frames.
// Define SPI_REG_MASTER_READBACK_EN to synchronise MISO and return captured bits on rdata.
module spi_reg_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        special_frame,
    input  logic [7:0]  addr,
    input  logic [7:0]  val,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        spi_clk,
    output logic        spi_cs,
    output logic        spi_special,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {StIdle, StPre, StSetup, StShift, StHold, StPost, StGap} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    bit_cnt_q;
    logic [15:0]   shreg_q;

`ifdef SPI_REG_MASTER_READBACK_EN
    logic        miso_q1, miso_q2;
    logic [15:0] capture_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_q1 <= 1'b0;
            miso_q2 <= 1'b0;
        end else begin
            miso_q1 <= spi_miso;
            miso_q2 <= miso_q1;
        end
    end
`else
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign rdata       = 16'h0000;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spi_clk     <= 1'b0;
            spi_cs      <= 1'b1;
            spi_special <= 1'b1;
            spi_mosi    <= 1'b0;
`ifdef SPI_REG_MASTER_READBACK_EN
            capture_q   <= '0;
            rdata       <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        shreg_q     <= {addr, val};
                        spi_special <= ~special_frame;
                        busy        <= 1'b1;
                        state_q     <= StPre;
                    end
                end
                StPre: begin
                    spi_cs   <= 1'b0;
                    spi_mosi <= shreg_q[15];
                    cnt_q    <= SETUP_LD;
                    state_q  <= StSetup;
                end
                StSetup: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        spi_clk   <= 1'b1;
                        bit_cnt_q <= '0;
                        cnt_q     <= DIV_LD;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (spi_clk) begin
                        spi_clk <= 1'b0;
                        cnt_q   <= DIV_LD;
                    end else begin
                        // Last cycle of the low phase: sample MISO, then open the next bit.
`ifdef SPI_REG_MASTER_READBACK_EN
                        capture_q <= {capture_q[14:0], miso_q2};
`endif
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 5'd15) begin
                            cnt_q   <= HOLD_LD;
                            state_q <= StHold;
                        end else begin
                            spi_clk  <= 1'b1;
                            spi_mosi <= shreg_q[14];
                            shreg_q  <= {shreg_q[14:0], 1'b0};
                            cnt_q    <= DIV_LD;
                        end
                    end
                end
                StHold: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        spi_cs  <= 1'b1;
                        done    <= 1'b1;
`ifdef SPI_REG_MASTER_READBACK_EN
                        rdata   <= capture_q;
`endif
                        state_q <= StPost;
                    end
                end
                StPost: begin
                    // SPECIAL outlives CS by one cycle so the commit edge sees it asserted.
                    spi_special <= 1'b1;
                    cnt_q       <= GAP_LD;
                    state_q     <= StGap;
                end
                StGap: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
